// File: rtl/nttn_driver.sv
// Host-side sequencer for the NTTN core: frames command/word streams onto din, fires start and
// forwards RING_SIZE result words. Define NTTN_DRV_TIMEOUT_EN to build the WAIT_DONE watchdog.
module nttn_driver #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned RING_DEPTH = 12,
  parameter int unsigned PE_DEPTH   = 3,
  parameter int unsigned GAP        = 5,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic [2:0]           err,
  input  logic                 err_clr,
  output logic                 load_w,
  output logic                 load_data,
  output logic                 start,
  output logic                 start_intt,
  output logic [DATA_SIZE-1:0] din,
  input  logic                 done,
  input  logic [DATA_SIZE-1:0] dout
);

  localparam int unsigned RING_SIZE = 1 << RING_DEPTH;
  localparam int unsigned W_COUNT   = ((1 << (RING_DEPTH - PE_DEPTH)) - 1 + PE_DEPTH) << PE_DEPTH;
  localparam int unsigned TW_WORDS  = 2 * W_COUNT + 2;

`ifdef NTTN_DRV_TIMEOUT_EN
  localparam int unsigned CntMaxT = TIMEOUT;
`else
  // No watchdog: TIMEOUT stays in the parameter list but sizes nothing.
  localparam int unsigned CntMaxT = (TIMEOUT > 0) ? 0 : 0;
`endif
  localparam int unsigned CntMaxA = (TW_WORDS > RING_SIZE) ? TW_WORDS : RING_SIZE;
  localparam int unsigned CntMaxB = (CntMaxA > GAP) ? CntMaxA : GAP;
  localparam int unsigned CntMax  = (CntMaxB > CntMaxT) ? CntMaxB : CntMaxT;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StLoadPulse, StStream, StGapWait, StFire, StWaitDone, StSkip, StCapture
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 w_loaded_q, w_loaded_d;
  logic [DATA_SIZE-1:0] din_q, din_d;
  logic [DATA_SIZE-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [2:0]           err_q, err_d, err_set;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    w_loaded_d = w_loaded_q;
    din_d      = '0;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    m_last_d   = 1'b0;
    err_set    = '0;
    cmd_ready  = 1'b0;
    s_ready    = 1'b0;
    load_w     = 1'b0;
    load_data  = 1'b0;
    start      = 1'b0;
    start_intt = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          if (cmd_op == 2'd3 || (cmd_op != 2'd0 && !w_loaded_q)) begin
            err_set[2] = 1'b1;
          end else begin
            op_d    = cmd_op;
            state_d = StLoadPulse;
          end
        end
      end
      StLoadPulse: begin
        // This cycle carries word 0 of the stream.
        s_ready   = 1'b1;
        load_w    = (op_q == 2'd0);
        load_data = (op_q != 2'd0);
        cnt_d     = CntW'(1);
        state_d   = StStream;
      end
      StStream: begin
        s_ready = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if ((op_q == 2'd0 && cnt_q == CntW'(TW_WORDS - 1)) ||
            (op_q != 2'd0 && cnt_q == CntW'(RING_SIZE - 1))) begin
          cnt_d = '0;
          if (op_q == 2'd0) begin
            w_loaded_d = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StGapWait;
          end
        end
      end
      StGapWait: begin
        // First cycle still shows the last word on din, so GAP zero cycles follow it.
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(GAP)) begin
          cnt_d   = '0;
          state_d = StFire;
        end
      end
      StFire: begin
        start      = (op_q == 2'd1);
        start_intt = (op_q == 2'd2);
        cnt_d      = '0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        if (done) begin
          state_d = StSkip;
`ifdef NTTN_DRV_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_set[1] = 1'b1;
          cnt_d      = '0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StSkip: begin
        cnt_d   = '0;
        state_d = StCapture;
      end
      StCapture: begin
        // RING_SIZE capture cycles plus one to present the final word.
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(RING_SIZE)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = dout;
          m_last_d  = (cnt_q == CntW'(RING_SIZE - 1));
        end
      end
      default: state_d = StIdle;
    endcase

    // NTTN cannot tolerate gaps, so a missing word becomes a zero slot plus an underrun flag.
    if (s_ready) begin
      din_d      = s_valid ? s_data : '0;
      err_set[0] = ~s_valid;
    end

    err_d = (err_clr ? 3'b000 : err_q) | err_set;
`ifndef NTTN_DRV_TIMEOUT_EN
    err_d[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= 2'd0;
      w_loaded_q <= 1'b0;
      din_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      w_loaded_q <= w_loaded_d;
      din_q      <= din_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

  assign din     = din_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign err     = err_q;

endmodule

// File: tb/tb_nttn_driver.sv
// Directed bench for nttn_driver with RING_DEPTH=4, PE_DEPTH=1 (TW_WORDS=34, RING_SIZE=16), GAP=5.
module tb_nttn_driver;

  localparam int unsigned DW = 64;
  localparam int RS = 16;
  localparam int TW = 34;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic          cmd_ready;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [2:0]    err;
  logic          err_clr = 1'b0;
  logic          load_w, load_data, start, start_intt;
  logic [DW-1:0] din;
  logic          done = 1'b0;
  logic [DW-1:0] dout = '0;

  nttn_driver #(
    .DATA_SIZE (DW),
    .RING_DEPTH(4),
    .PE_DEPTH  (1),
    .GAP       (5),
    .TIMEOUT   (50)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .err       (err),
    .err_clr   (err_clr),
    .load_w    (load_w),
    .load_data (load_data),
    .start     (start),
    .start_intt(start_intt),
    .din       (din),
    .done      (done),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_lw = 0, n_ld = 0, n_st = 0, n_si = 0, n_mv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_w)     n_lw <= n_lw + 1;
    if (load_data)  n_ld <= n_ld + 1;
    if (start)      n_st <= n_st + 1;
    if (start_intt) n_si <= n_si + 1;
    if (m_valid)    n_mv <= n_mv + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a command in the current cycle; returns its acceptance cycle.
  task automatic issue(input logic [1:0] op, output int t);
    t         = cyc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    check_eq("cmd_ready_at_issue", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
  endtask

  // Called in cycle T+1; leaves off in cycle T+17.
  task automatic stream_data(input int hole);
    for (int i = 0; i < RS; i++) begin
      s_valid = (i != hole);
      s_data  = (i == hole) ? 64'hdead : 64'(100 + i);
      check_eq("s_ready_data", s_ready, 1);
      tick;
      check_eq("din_data", din, (i == hole) ? 64'd0 : 64'(100 + i));
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_fire(input int t0);
    for (int n = 0; n < 40 && !(start || start_intt); n++) tick;
    check_eq("start_cycle", 64'(cyc - t0), 64'd23);
    check_eq("start_pulse", start, 1);
    check_eq("start_intt_quiet", start_intt, 0);
  endtask

  int t, d, mv0, lw0, ld0, st0;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_load_w", load_w, 0);
    reset = 1'b0;
    tick;

    // INTT without twiddles is dropped.
    issue(2'd2, t);
    check_eq("nowt_err", err, 3'b100);
    check_eq("nowt_cmd_ready", cmd_ready, 1);
    repeat (3) tick;
    check_eq("nowt_load_data", n_ld, 0);
    check_eq("nowt_start_intt", n_si, 0);
    check_eq("nowt_s_ready", s_ready, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check_eq("err_clr", err, 0);

    // Reserved op while clearing: set wins.
    err_clr = 1'b1;
    issue(2'd3, t);
    err_clr = 1'b0;
    check_eq("set_beats_clr", err, 3'b100);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check_eq("err_clr2", err, 0);

    // Twiddle load: 34 words.
    lw0 = n_lw;
    issue(2'd0, t);
    check_eq("tw_load_w", load_w, 1);
    check_eq("tw_load_data", load_data, 0);
    for (int k = 0; k < TW; k++) begin
      s_valid = 1'b1;
      s_data  = 64'(k);
      check_eq("tw_s_ready", s_ready, 1);
      tick;
      check_eq("tw_din", din, 64'(k));
      check_eq("tw_cmd_ready", cmd_ready, (k == TW - 1) ? 1 : 0);
    end
    s_valid = 1'b0;
    s_data  = '0;
    check_eq("tw_idle_s_ready", s_ready, 0);
    tick;
    check_eq("tw_din_back0", din, 0);
    check_eq("tw_load_w_count", n_lw - lw0, 1);
    check_eq("tw_err", err, 0);

    // Full NTT; a done pulse during GAP_WAIT must be ignored.
    ld0 = n_ld;
    st0 = n_st;
    mv0 = n_mv;
    issue(2'd1, t);
    check_eq("ntt_load_data", load_data, 1);
    check_eq("ntt_load_w", load_w, 0);
    stream_data(-1);
    done = 1'b1;
    tick;
    done = 1'b0;
    check_eq("ntt_gap_din", din, 0);
    wait_fire(t);
    tick;
    tick;
    tick;
    done = 1'b1;
    d    = cyc;
    tick;
    done = 1'b0;
    check_eq("ntt_skip_m_valid", m_valid, 0);
    tick;
    check_eq("ntt_cap_m_valid", m_valid, 0);
    for (int i = 0; i < RS; i++) begin
      dout = 64'(200 + i);
      tick;
      check_eq("ntt_m_valid", m_valid, 1);
      check_eq("ntt_m_data", m_data, 64'(200 + i));
      check_eq("ntt_m_last", m_last, (i == RS - 1) ? 1 : 0);
      check_eq("ntt_cmd_ready_busy", cmd_ready, 0);
    end
    dout = '0;
    tick;
    check_eq("ntt_end_m_valid", m_valid, 0);
    check_eq("ntt_end_cmd_ready", cmd_ready, 1);
    check_eq("ntt_end_cycle", 64'(cyc - d), 64'(RS + 3));
    check_eq("ntt_start_count", n_st - st0, 1);
    check_eq("ntt_load_data_count", n_ld - ld0, 1);
    check_eq("ntt_m_valid_count", n_mv - mv0, RS);
    check_eq("ntt_err", err, 0);

    // No done: watchdog build times out, default build keeps waiting.
    issue(2'd1, t);
    stream_data(-1);
    wait_fire(t);
    d   = cyc;
    mv0 = n_mv;
`ifdef NTTN_DRV_TIMEOUT_EN
    repeat (50) tick;
    check_eq("to_err_before", err[1], 0);
    check_eq("to_busy", cmd_ready, 0);
    tick;
    check_eq("to_err", err[1], 1);
    check_eq("to_idle", cmd_ready, 1);
    check_eq("to_no_m_valid", n_mv - mv0, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
`else
    repeat (60) tick;
    check_eq("wait_err", err, 0);
    check_eq("wait_busy", cmd_ready, 0);
    check_eq("wait_no_m_valid", n_mv - mv0, 0);
    done = 1'b1;
    tick;
    done = 1'b0;
    repeat (RS + 2) tick;
    check_eq("wait_drain_idle", cmd_ready, 1);
    check_eq("wait_drain_count", n_mv - mv0, RS);
`endif

    // Underrun on word 7, then reset mid-capture.
    issue(2'd1, t);
    stream_data(7);
    check_eq("ur_err", err, 3'b001);
    wait_fire(t);
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      dout = 64'(300 + i);
      tick;
    end
    check_eq("ur_m_data", m_data, 64'd303);
    check_eq("ur_m_valid", m_valid, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("mrst_m_valid", m_valid, 0);
    check_eq("mrst_cmd_ready", cmd_ready, 1);
    check_eq("mrst_err", err, 0);
    mv0 = n_mv;
    ld0 = n_ld;
    tick;
    issue(2'd1, t);
    check_eq("mrst_nowt_err", err, 3'b100);
    check_eq("mrst_cmd_ready2", cmd_ready, 1);
    repeat (3) tick;
    check_eq("mrst_no_m_valid", n_mv - mv0, 0);
    check_eq("mrst_no_load_data", n_ld - ld0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
